i2s_tx_fifo: RTL and testbench
==============================

# i2s_tx_fifo

Output stage directly downstream of the DSP engine. It buffers the engine's processed stereo 24-bit samples in a small FIFO and serializes them as a standard I2S master stream (BCLK, LRCLK, SDATA) toward an external DAC. The DSP engine's valid strobe has no backpressure, so this block absorbs rate jitter, drops samples on overflow and zero-fills on underrun, with sticky status flags for the register bank.

## Interface
- DEPTH, 8: FIFO entries; each entry holds one stereo pair (48 bits). Must be a power of two, ≥2.
- CLK_DIV, 4: clk cycles per BCLK half-period; ≥1.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  push strobe, one stereo sample per pulse (DSP engine out_valid)
- in_l  in  24  left sample, two's complement
- in_r  in  24  right sample, two's complement
- enable  in  1  1 = run serializer; 0 = hold serial outputs idle
- clr_flags  in  1  single-cycle clear of the sticky flags
- bclk  out  1  bit clock
- lrclk  out  1  word select, 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- fifo_level  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a push was dropped
- underrun  out  1  sticky: a frame was loaded while the FIFO was empty

## Operation
- One clock; reset is asynchronous and active-high.
- Reset values: bclk=0, lrclk=0, sdata=0, fifo_level=0, overflow=0, underrun=0. Divider counter=0, bit_cnt=63, shift registers=0, FIFO pointers=0.
- FIFO: circular buffer with wrapping read/write pointers.
  - A push is accepted when in_valid=1 and either level<DEPTH or a pop occurs in the same cycle.
  - When full with no pop, the sample is dropped, level stays unchanged and overflow is set.
  - Simultaneous push and pop leaves level unchanged.
- Divider (enable=1):
  - Counter runs 0..CLK_DIV-1. On reaching CLK_DIV-1 it wraps to 0 and toggles bclk.
  - A toggle from 1 to 0 generates an internal fall strobe in that same cycle.
- On each fall strobe, bit_cnt <= bit_cnt+1 mod 64. All outputs are registered in that cycle from the new value n:
  - Frame load when n==0:
    - FIFO not empty: pop one entry into sh_l/sh_r.
    - FIFO empty: load zeros and set underrun.
  - lrclk = n[5].
  - Slot index s = n[4:0]. Channel word is sh_l when n[5]=0, sh_r otherwise.
  - sdata = word[24-s] for s in 1..24; otherwise 0.
  - This gives standard I2S: a 1-BCLK data delay after each LRCLK edge, 24 data bits, then 8 zero bits in a 32-bit slot.
- enable=0:
  - Divider is forced to 0, bit_cnt to 63; bclk, lrclk and sdata are driven 0.
  - No pops occur; the FIFO keeps accepting pushes.
  - Deasserting enable mid-frame abandons the current frame. Re-enabling restarts at a fresh frame with a new pop.
- Flags:
  - clr_flags clears both flags.
  - If a set event and clr_flags coincide, set wins.
- Reset mid-operation returns everything to reset values immediately. FIFO contents are discarded.

## Timing
- BCLK period = 2·CLK_DIV clk. Frame = 64 BCLK = 128·CLK_DIV clk.
- Sustainable input rate is one push per 128·CLK_DIV clk on average.
- After enable rises:
  - bclk rises after CLK_DIV cycles.
  - The first fall strobe, and therefore the pop, occurs at 2·CLK_DIV cycles.
  - The left MSB appears on sdata at the second fall strobe, 4·CLK_DIV cycles after enable.
- fifo_level updates the cycle after a push or pop.
- A push arriving in the same cycle the FIFO is empty and a frame load happens is not seen by that load. That frame underruns.
- sdata and lrclk change only in fall-strobe cycles, so they are stable across every bclk rising edge.

## Test plan
- Reset: assert rst mid-frame with level=3 → next cycle all outputs are 0 and fifo_level=0. No bclk edges appear until enable.
- Single frame: CLK_DIV=4, push L=0x800001, R=0x7FFFFE, then enable=1 → bclk period is 8 clk. The L slot serializes 1,0…0,1 then 8 zeros with lrclk=0; the R slot serializes 0,1…1,0 with lrclk=1; level goes 1→0 at the first pop.
- Overflow: DEPTH=8, enable=0, 10 pushes → fifo_level=8, overflow=1, and the first 8 samples are later output in order.
- Underrun: enable with the FIFO empty → frame is all zeros and underrun=1. clr_flags then clears it; a simultaneous set and clear leaves underrun=1.
- Full plus pop: level=8 with a push in the exact frame-load cycle → push accepted, level stays 8, overflow stays 0.
- Streaming: pushes every 512 clk (CLK_DIV=4) for 100 frames → no flags are set and output words match the inputs bit-exactly, including wrap-around of the pointers.

Source files
------------

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: stereo sample FIFO feeding an I2S master serializer.
// Buffers 24-bit L/R pairs from the DSP engine and streams them out as
// 64-BCLK frames (two 32-bit slots, 24 data bits MSB first, 1-BCLK delay).
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   in_valid/in_l/in_r  push strobe and stereo sample (no backpressure)
//   enable              run serializer; 0 holds serial outputs idle
//   clr_flags           single-cycle clear of the sticky flags
//   bclk/lrclk/sdata    I2S master outputs (registered)
//   fifo_level          current FIFO occupancy
//   overflow/underrun   sticky status flags
module i2s_tx_fifo #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [23:0]              in_l,
   input  logic [23:0]              in_r,
   input  logic                     enable,
   input  logic                     clr_flags,
   output logic                     bclk,
   output logic                     lrclk,
   output logic                     sdata,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic                     underrun
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned SW = 24;

   logic [2*SW-1:0] mem_q [DEPTH];

   logic [DW-1:0]   div_q, div_d;
   logic            bclk_q, bclk_d;
   logic [5:0]      bit_cnt_q, bit_cnt_d;
   logic [SW-1:0]   sh_l_q, sh_l_d;
   logic [SW-1:0]   sh_r_q, sh_r_d;
   logic            lrclk_q, lrclk_d;
   logic            sdata_q, sdata_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            ovf_q, ovf_d;
   logic            udr_q, udr_d;

   logic            fall;
   logic            pop;
   logic            push;
   logic            udr_evt;
   logic            ovf_evt;
   logic [5:0]      n;
   logic [4:0]      slot;
   logic [4:0]      bit_idx;
   logic [SW-1:0]   word;

   // Divider, bit counter, frame load and serial output selection
   always_comb begin
      div_d     = div_q;
      bclk_d    = bclk_q;
      bit_cnt_d = bit_cnt_q;
      sh_l_d    = sh_l_q;
      sh_r_d    = sh_r_q;
      lrclk_d   = lrclk_q;
      sdata_d   = sdata_q;
      fall      = 1'b0;
      pop       = 1'b0;
      udr_evt   = 1'b0;
      n         = bit_cnt_q;
      slot      = 5'd0;
      bit_idx   = 5'd0;
      word      = '0;

      if (!enable) begin
         div_d     = '0;
         bclk_d    = 1'b0;
         bit_cnt_d = 6'd63;
         lrclk_d   = 1'b0;
         sdata_d   = 1'b0;
      end else if (div_q == DW'(CLK_DIV - 1)) begin
         div_d  = '0;
         bclk_d = ~bclk_q;
         fall   = bclk_q;
      end else begin
         div_d = div_q + DW'(1);
      end

      if (fall) begin
         n         = bit_cnt_q + 6'd1;
         bit_cnt_d = n;
         // Frame boundary: pop a pair, or zero-fill when nothing is buffered
         if (n == 6'd0) begin
            if (level_q != '0) begin
               pop              = 1'b1;
               {sh_l_d, sh_r_d} = mem_q[rd_ptr_q];
            end else begin
               sh_l_d  = '0;
               sh_r_d  = '0;
               udr_evt = 1'b1;
            end
         end
         lrclk_d = n[5];
         slot    = n[4:0];
         word    = n[5] ? sh_r_d : sh_l_d;
         // Slot 0 is the I2S delay bit; slots 25..31 pad with zeros
         if (slot >= 5'd1 && slot <= 5'd24) begin
            bit_idx = 5'd24 - slot;
            sdata_d = word[bit_idx];
         end else begin
            sdata_d = 1'b0;
         end
      end
   end

   // FIFO bookkeeping and sticky flags (a set event beats a clear)
   always_comb begin
      push     = in_valid && ((level_q != LW'(DEPTH)) || pop);
      ovf_evt  = in_valid && !push;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + LW'(push) - LW'(pop);
      ovf_d    = (ovf_q && !clr_flags) || ovf_evt;
      udr_d    = (udr_q && !clr_flags) || udr_evt;
   end

   // Sample storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_l, in_r};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         bclk_q    <= 1'b0;
         bit_cnt_q <= 6'd63;
         sh_l_q    <= '0;
         sh_r_q    <= '0;
         lrclk_q   <= 1'b0;
         sdata_q   <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ovf_q     <= 1'b0;
         udr_q     <= 1'b0;
      end else begin
         div_q     <= div_d;
         bclk_q    <= bclk_d;
         bit_cnt_q <= bit_cnt_d;
         sh_l_q    <= sh_l_d;
         sh_r_q    <= sh_r_d;
         lrclk_q   <= lrclk_d;
         sdata_q   <= sdata_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ovf_q     <= ovf_d;
         udr_q     <= udr_d;
      end
   end

   assign bclk       = bclk_q;
   assign lrclk      = lrclk_q;
   assign sdata      = sdata_q;
   assign fifo_level = level_q;
   assign overflow   = ovf_q;
   assign underrun   = udr_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: directed bench for i2s_tx_fifo (DEPTH=8, CLK_DIV=4).
// A frame decoder runs inside tick(): it samples sdata/lrclk on every bclk
// rising edge and rebuilds the L/R words of each complete 64-bit frame.
module tb_i2s_tx_fifo;

   localparam int unsigned DEPTH   = 8;
   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned LW      = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [23:0]   in_l = '0;
   logic [23:0]   in_r = '0;
   logic          enable = 1'b0;
   logic          clr_flags = 1'b0;
   logic          bclk, lrclk, sdata, overflow, underrun;
   logic [LW-1:0] fifo_level;

   i2s_tx_fifo #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_l       (in_l),
      .in_r       (in_r),
      .enable     (enable),
      .clr_flags  (clr_flags),
      .bclk       (bclk),
      .lrclk      (lrclk),
      .sdata      (sdata),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   int          n_assert;
   int          n_fail;
   int          n_rise;
   int          m_cyc;
   int          m_per;
   int          m_pos;
   logic        m_have;
   logic        m_prev;
   logic [63:0] m_sd;
   logic [63:0] m_lr;
   logic [23:0] q_l [$];
   logic [23:0] q_r [$];
   logic        q_ok [$];

   function automatic logic [23:0] ol(input int k);
      return 24'(32'h00C00000 | (k * 32'h00000111));
   endfunction
   function automatic logic [23:0] orr(input int k);
      return 24'(32'h00300000 + (k * 32'h00010101));
   endfunction
   function automatic logic [23:0] sl(input int k);
      return 24'((k * 32'h0009E377) ^ 32'h00A5C3F1);
   endfunction
   function automatic logic [23:0] sr(input int k);
      return 24'((k * 32'h00031415) + 32'h00800001);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling clk edge and run the frame decoder
   task automatic tick();
      logic        en_now;
      logic        rise;
      logic        ok;
      logic [23:0] fl;
      logic [23:0] fr;
      en_now = enable;
      @(negedge clk);
      m_cyc++;
      rise = bclk && !m_prev;
      if (rise) begin
         n_rise++;
         m_per = m_cyc;
         m_cyc = 0;
      end
      if (rst || !en_now) begin
         m_pos  = 62;
         m_have = 1'b0;
      end else if (rise) begin
         m_pos = (m_pos + 1) % 64;
         m_sd[m_pos] = sdata;
         m_lr[m_pos] = lrclk;
         if (m_pos == 0) m_have = 1'b1;
         if (m_pos == 63 && m_have) begin
            ok = 1'b1;
            for (int i = 0; i < 24; i++) begin
               fl[23-i] = m_sd[1+i];
               fr[23-i] = m_sd[33+i];
            end
            for (int p = 0; p < 64; p++) begin
               if (m_lr[p] !== logic'(p >= 32)) ok = 1'b0;
               if ((p == 0 || (p >= 25 && p <= 32) || p >= 57) && m_sd[p] !== 1'b0) ok = 1'b0;
            end
            q_l.push_back(fl);
            q_r.push_back(fr);
            q_ok.push_back(ok);
         end
      end
      m_prev = bclk;
   endtask

   task automatic q_clear();
      q_l.delete();
      q_r.delete();
      q_ok.delete();
   endtask

   task automatic wait_frames(input int need, input int budget, input string tag);
      int c = 0;
      while (q_l.size() < need && c < budget) begin
         tick();
         c++;
      end
      chk(tag, 64'(q_l.size()), 64'(need));
   endtask

   task automatic chk_frame(input int idx, input logic [23:0] el, input logic [23:0] er);
      chk($sformatf("frame%0d_l", idx), 64'(q_l[idx]), 64'(el));
      chk($sformatf("frame%0d_r", idx), 64'(q_r[idx]), 64'(er));
      chk($sformatf("frame%0d_fmt", idx), 64'(q_ok[idx]), 64'd1);
   endtask

   initial begin
      int r0;
      n_assert = 0;
      n_fail   = 0;
      n_rise   = 0;
      m_cyc    = 0;
      m_per    = 0;
      m_pos    = 62;
      m_have   = 1'b0;
      m_prev   = 1'b0;
      m_sd     = '0;
      m_lr     = '0;

      // Reset state and idle with enable low
      repeat (3) tick();
      chk("rst_outs", 64'({bclk, lrclk, sdata, overflow, underrun}), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      rst = 1'b0;
      repeat (4) tick();
      chk("idle_no_bclk", 64'(n_rise), 64'd0);

      // Single frame: timing after enable and bit-exact words
      in_valid = 1'b1; in_l = 24'h800001; in_r = 24'h7FFFFE;
      tick();
      in_valid = 1'b0;
      tick();
      chk("sf_level_push", 64'(fifo_level), 64'd1);
      q_clear();
      enable = 1'b1;
      repeat (3) tick();
      chk("sf_bclk_low_c3", 64'(bclk), 64'd0);
      tick();
      chk("sf_bclk_rise_c4", 64'(bclk), 64'd1);
      repeat (3) tick();
      chk("sf_level_c7", 64'(fifo_level), 64'd1);
      tick();
      chk("sf_level_pop_c8", 64'(fifo_level), 64'd0);
      repeat (7) tick();
      chk("sf_delay_bit_c15", 64'(sdata), 64'd0);
      tick();
      chk("sf_msb_c16", 64'({lrclk, sdata}), 64'b01);
      chk("sf_no_underrun", 64'(underrun), 64'd0);
      wait_frames(2, 1200, "sf_frames");
      enable = 1'b0;
      tick();
      chk("disable_idle", 64'({bclk, lrclk, sdata}), 64'd0);
      chk_frame(0, 24'h800001, 24'h7FFFFE);
      chk("bclk_period", 64'(m_per), 64'(2 * CLK_DIV));
      // Second frame found the FIFO empty
      chk_frame(1, 24'h000000, 24'h000000);
      chk("underrun_set", 64'(underrun), 64'd1);

      // Clear, then set and clear in the same cycle
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("underrun_clr", 64'(underrun), 64'd0);
      q_clear();
      enable = 1'b1;
      repeat (7) tick();
      chk("underrun_pre_load", 64'(underrun), 64'd0);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("underrun_set_wins", 64'(underrun), 64'd1);
      enable = 1'b0;
      tick();
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("underrun_clr2", 64'(underrun), 64'd0);

      // Overflow: ten pushes into an idle FIFO of eight
      for (int k = 0; k < 10; k++) begin
         if (k == 8) begin
            chk("ovf_level_full", 64'(fifo_level), 64'd8);
            chk("ovf_not_yet", 64'(overflow), 64'd0);
         end
         in_valid = 1'b1; in_l = ol(k); in_r = orr(k);
         tick();
      end
      in_valid = 1'b0;
      chk("ovf_level", 64'(fifo_level), 64'd8);
      chk("ovf_set", 64'(overflow), 64'd1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      chk("ovf_clr", 64'(overflow), 64'd0);

      // Full FIFO with a push landing exactly on the frame-load cycle
      q_clear();
      enable = 1'b1;
      repeat (7) tick();
      in_valid = 1'b1; in_l = 24'h0BEEF1; in_r = 24'hFACE02;
      tick();
      in_valid = 1'b0;
      chk("fp_level", 64'(fifo_level), 64'd8);
      chk("fp_no_ovf", 64'(overflow), 64'd0);
      wait_frames(9, 9 * 512 + 200, "fp_frames");
      enable = 1'b0;
      tick();
      for (int i = 0; i < 8; i++) chk_frame(i, ol(i), orr(i));
      chk_frame(8, 24'h0BEEF1, 24'hFACE02);
      chk("fp_flags", 64'({overflow, underrun}), 64'd0);

      // Asynchronous reset mid-frame with three entries buffered
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_l = sl(200 + k); in_r = sr(200 + k);
         tick();
      end
      in_valid = 1'b0;
      enable = 1'b1;
      repeat (108) tick();
      chk("mr_level", 64'(fifo_level), 64'd3);
      @(posedge clk);
      #2;
      rst = 1'b1;
      enable = 1'b0;
      tick();
      chk("mr_outs", 64'({bclk, lrclk, sdata, overflow, underrun}), 64'd0);
      chk("mr_level_zero", 64'(fifo_level), 64'd0);
      rst = 1'b0;
      r0 = n_rise;
      repeat (50) tick();
      chk("mr_no_bclk", 64'(n_rise), 64'(r0));

      // Streaming: one push per frame for 100 frames, pointers wrap
      q_clear();
      for (int k = 0; k < 100; k++) begin
         in_valid = 1'b1; in_l = sl(k); in_r = sr(k);
         tick();
         in_valid = 1'b0;
         if (k == 0) enable = 1'b1;
         repeat (511) tick();
      end
      wait_frames(100, 600, "st_frames");
      enable = 1'b0;
      tick();
      for (int i = 0; i < 100; i++) chk_frame(i, sl(i), sr(i));
      chk("st_flags", 64'({overflow, underrun}), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
